// File: rtl/bcd_count_display_if.sv
// Control inputs and count/display outputs of the BCD counter-display block.
// The slave modport is the counter; the master modport is whoever drives it.
interface bcd_count_display_if;
    logic        ce;
    logic        start;
    logic        clr;
    logic        up;
    logic [15:0] count;
    logic        carry;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    modport master (
        output ce, start, clr, up,
        input  count, carry, seg, dp, an
    );

    modport slave (
        input  ce, start, clr, up,
        output count, carry, seg, dp, an
    );
endinterface

// File: rtl/bcd_count_display.sv
// 4-digit BCD up/down counter with run/hold/clear control, driving a
// time-multiplexed active-low common-anode 7-segment display.
module bcd_count_display #(
    parameter int SCAN_DIV = 10000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bcd_count_display_if.slave   bus
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t        state, state_nxt;
    logic          start_d;
    logic          start_edge;
    logic [15:0]   count_q, count_nxt;
    logic          carry_q, carry_nxt;
    logic [16:0]   stepped;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    idx, idx_nxt;
    logic          scan_tc;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic [3:0]    an_q;

    // Ripple one BCD step through the digits; bit 16 is the whole-counter wrap.
    function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic up);
        logic [15:0] r;
        logic        cy;
        r  = v;
        cy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (cy) begin
                if (up) begin
                    if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
                    else begin r[4*i +: 4] = v[4*i +: 4] + 4'd1; cy = 1'b0; end
                end else begin
                    if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
                    else begin r[4*i +: 4] = v[4*i +: 4] - 4'd1; cy = 1'b0; end
                end
            end
        end
        return {cy, r};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    assign start_edge = bus.start & ~start_d;
    assign stepped    = bcd_step(count_q, bus.up);

    always_comb begin
        state_nxt = state;
        count_nxt = count_q;
        carry_nxt = 1'b0;
        if (bus.clr) begin
            state_nxt = IDLE;
            count_nxt = 16'h0000;
        end else begin
            case (state)
                IDLE:    if (start_edge) state_nxt = RUN;
                RUN:     if (start_edge) state_nxt = HOLD;
                HOLD:    if (start_edge) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
            // Counting keys off the pre-edge state, so the CE that arrives
            // with the IDLE->RUN edge is dropped and the one with RUN->HOLD counts.
            if (state == RUN && bus.ce) begin
                count_nxt = stepped[15:0];
                carry_nxt = stepped[16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_d <= 1'b0;
            count_q <= 16'h0000;
            carry_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            start_d <= bus.start;
            count_q <= count_nxt;
            carry_q <= carry_nxt;
        end
    end

    assign scan_tc = (scan_cnt == SW'(SCAN_DIV - 1));
    assign idx_nxt = idx + 2'd1;

    // Anode, segments and DP all load from the new index on one edge, so
    // segment data can never lag the anode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
            an_q     <= 4'b1110;
            seg_q    <= 7'b1000000;
            dp_q     <= 1'b1;
        end else if (scan_tc) begin
            scan_cnt <= '0;
            idx      <= idx_nxt;
            an_q     <= ~(4'b0001 << idx_nxt);
            seg_q    <= seg7(count_q[4*idx_nxt +: 4]);
            dp_q     <= ~(state == HOLD && idx_nxt == 2'd0);
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    assign bus.count = count_q;
    assign bus.carry = carry_q;
    assign bus.seg   = seg_q;
    assign bus.dp    = dp_q;
    assign bus.an    = an_q;
endmodule

// File: tb/tb_bcd_count_display.sv
// Randomized and directed bench for bcd_count_display against an
// arithmetic (decimal integer) reference model.
module tb_bcd_count_display;
    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    bcd_count_display_if bus ();

    bcd_count_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // reference model: count as a plain integer 0..9999, state as 0/1/2
    localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2;
    int         m_cnt, m_st, m_cyc;
    logic       m_start_d, m_carry;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    logic       m_dp;
    logic [6:0] glyph [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic int pow10(input int d);
        int p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_st = M_IDLE; m_cyc = 0; m_start_d = 1'b0; m_carry = 1'b0;
        m_an = 4'b1110; m_seg = glyph[0]; m_dp = 1'b1;
    endtask

    task automatic model_step(input logic ce, input logic st, input logic clr, input logic up);
        int pre_cnt = m_cnt;
        int pre_st  = m_st;
        int dig;
        m_carry = 1'b0;
        if (clr) begin
            m_st = M_IDLE; m_cnt = 0;
        end else begin
            if (st && !m_start_d) m_st = (m_st == M_RUN) ? M_HOLD : M_RUN;
            if (pre_st == M_RUN && ce) begin
                if (up) begin m_carry = (pre_cnt == 9999); m_cnt = (pre_cnt + 1) % 10000; end
                else    begin m_carry = (pre_cnt == 0);    m_cnt = (pre_cnt + 9999) % 10000; end
            end
        end
        m_start_d = st;
        m_cyc++;
        if (m_cyc % SCAN_DIV == 0) begin
            dig   = (m_cyc / SCAN_DIV) % 4;
            m_an  = ~(4'b0001 << dig);
            m_seg = glyph[(pre_cnt / pow10(dig)) % 10];
            m_dp  = !(pre_st == M_HOLD && dig == 0);
        end
    endtask

    task automatic check_all();
        chk("count", {16'h0, bus.count}, {16'h0, to_bcd(m_cnt)});
        chk("carry", {31'h0, bus.carry}, {31'h0, m_carry});
        chk("an",    {28'h0, bus.an},    {28'h0, m_an});
        chk("seg",   {25'h0, bus.seg},   {25'h0, m_seg});
        chk("dp",    {31'h0, bus.dp},    {31'h0, m_dp});
    endtask

    // Inputs are set 1 time unit after an edge; outputs sampled 1 unit after the next.
    task automatic tick(input logic ce, input logic st, input logic clr, input logic up);
        bus.ce = ce; bus.start = st; bus.clr = clr; bus.up = up;
        @(posedge clk);
        model_step(ce, st, clr, up);
        #1;
        check_all();
    endtask

    task automatic run_ce(input int n, input logic up);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 1'b0, up);
    endtask

    task automatic start_pulse(input logic ce);
        tick(ce, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic clear();
        tick(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        bus.ce = 0; bus.start = 0; bus.clr = 0; bus.up = 1;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;
        chk("rst_an",  {28'h0, bus.an},  32'hE);
        chk("rst_seg", {25'h0, bus.seg}, 32'h40);

        // 12 counts up; CE alongside the IDLE->RUN edge is dropped
        start_pulse(1'b1);
        run_ce(12, 1'b1);
        chk("t1_count", {16'h0, bus.count}, 32'h0012);

        // wrap both ways
        clear();
        start_pulse(1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_down_cnt",   {16'h0, bus.count}, 32'h9999);
        chk("t2_down_carry", {31'h0, bus.carry}, 32'h1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t2_up_cnt",   {16'h0, bus.count}, 32'h0000);
        chk("t2_up_carry", {31'h0, bus.carry}, 32'h1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_carry_1cyc", {31'h0, bus.carry}, 32'h0);

        // digit carry and borrow
        run_ce(9, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t3_0010", {16'h0, bus.count}, 32'h0010);
        run_ce(90, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t3_0099", {16'h0, bus.count}, 32'h0099);

        // CLR beats CE, then IDLE ignores CE
        run_ce(24, 1'b1);
        chk("t4_0123", {16'h0, bus.count}, 32'h0123);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t4_clr_cnt",   {16'h0, bus.count}, 32'h0000);
        chk("t4_clr_carry", {31'h0, bus.carry}, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4_idle_cnt", {16'h0, bus.count}, 32'h0000);

        // CE coincident with RUN->HOLD counts, then HOLD freezes and lights DP on digit 0
        start_pulse(1'b0);
        run_ce(41, 1'b1);
        start_pulse(1'b1);
        chk("t5_0042", {16'h0, bus.count}, 32'h0042);
        run_ce(3 * SCAN_DIV, 1'b1);
        for (int k = 0; k < 5 * SCAN_DIV && bus.an != 4'b1110; k++) tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t5_an0",  {28'h0, bus.an}, 32'hE);
        chk("t5_dp",   {31'h0, bus.dp}, 32'h0);
        chk("t5_hold", {16'h0, bus.count}, 32'h0042);

        // scan order and decode at 1234, then reset mid-scan
        clear();
        start_pulse(1'b0);
        run_ce(1234, 1'b1);
        start_pulse(1'b0);
        for (int k = 0; k < 5 * SCAN_DIV && bus.an != 4'b1110; k++) tick(1'b0, 1'b0, 1'b0, 1'b1);
        for (int d = 1; d < 4; d++) begin
            for (int k = 0; k < SCAN_DIV; k++) tick(1'b0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("t6_an%0d", d),  {28'h0, bus.an},
                (d == 1) ? 32'hD : (d == 2) ? 32'hB : 32'h7);
            chk($sformatf("t6_seg%0d", d), {25'h0, bus.seg},
                (d == 1) ? 32'h30 : (d == 2) ? 32'h24 : 32'h79);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_an",  {28'h0, bus.an},    32'hE);
        chk("t6_rst_seg", {25'h0, bus.seg},   32'h40);
        chk("t6_rst_cnt", {16'h0, bus.count}, 32'h0);
        check_all();
        #1 rst_n = 1'b1;

        // random traffic against the model
        begin
            logic st = 1'b0;
            logic up = 1'b1;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(0, 19) == 0) st = ~st;
                if ($urandom_range(0, 49) == 0) up = ~up;
                tick($urandom_range(0, 2) != 0, st, $urandom_range(0, 199) == 0, up);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
